// File: rtl/adc_capture_sequencer.sv
// Paces ADC frames from a sample-rate divider, sequences convst/busy/read per
// channel and hands each captured word downstream over a valid/ready handshake.
module adc_capture_sequencer #(
  parameter int NCH          = 8,
  parameter int DW           = 12,
  parameter int SAMPLE_DIV   = 1250,
  parameter int CONV_LOW     = 2,
  parameter int RD_CYCLES    = 3,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                     clkin,
  input  logic                     rst_bar,
  input  logic                     en,
  input  logic                     adc_busy,
  input  logic [DW-1:0]            adc_db,
  output logic                     adc_convst_bar,
  output logic                     adc_cs_bar,
  output logic                     adc_rd_bar,
  output logic [$clog2(NCH)-1:0]   adc_addr,
  output logic [DW-1:0]            dout,
  output logic [$clog2(NCH)-1:0]   dout_ch,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     overrun,
  output logic                     timeout_err
);

  localparam int AW   = $clog2(NCH);
  localparam int DVW  = $clog2(SAMPLE_DIV);
  localparam int CMAX = (BUSY_TIMEOUT > CONV_LOW)
                        ? ((BUSY_TIMEOUT > RD_CYCLES) ? BUSY_TIMEOUT : RD_CYCLES)
                        : ((CONV_LOW > RD_CYCLES) ? CONV_LOW : RD_CYCLES);
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT, S_READ, S_HOLD, S_NEXT
  } state_t;

  state_t          state, nxt;
  logic [DVW-1:0]  div_q;
  logic            tick;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   chan;
  logic            busy_p0, busy_p1;
  logic            seen_rise;
  logic            busy_fall;
  logic            to_hit;
  logic            last_rd;
  logic            last_ch;

  assign tick      = en && (div_q == DVW'(SAMPLE_DIV - 1));
  assign busy_fall = seen_rise && !busy_p1;
  assign to_hit    = (state == S_WAIT) && !busy_fall && (cnt == CW'(BUSY_TIMEOUT - 1));
  assign last_rd   = (state == S_READ) && (cnt == CW'(RD_CYCLES - 1));
  assign last_ch   = (chan == AW'(NCH - 1));
  assign adc_addr  = chan;

  always_ff @(posedge clkin or negedge rst_bar) begin
    if (!rst_bar)        div_q <= '0;
    else if (!en || tick) div_q <= '0;
    else                 div_q <= div_q + 1'b1;
  end

  // ---- busy synchroniser: p0 -> p1, p1 is the usable level
  always_ff @(posedge clkin or negedge rst_bar) begin
    if (!rst_bar) begin
      busy_p0 <= 1'b0;
      busy_p1 <= 1'b0;
    end else begin
      busy_p0 <= adc_busy;
      busy_p1 <= busy_p0;
    end
  end

  always_ff @(posedge clkin or negedge rst_bar) begin
    if (!rst_bar) state <= S_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (tick) nxt = S_START;
      S_START: if (cnt == CW'(CONV_LOW)) nxt = S_WAIT;
      S_WAIT:  if (busy_fall) nxt = S_READ;
               else if (to_hit) nxt = S_NEXT;
      S_READ:  if (last_rd) nxt = S_HOLD;
      S_HOLD:  if (dout_valid && dout_ready) nxt = S_NEXT;
      S_NEXT:  nxt = last_ch ? S_IDLE : S_START;
      default: nxt = S_IDLE;
    endcase
  end

  // First START cycle keeps convst high so a freshly changed adc_addr settles.
  always_comb begin
    adc_convst_bar = !((state == S_START) && (cnt != '0));
    adc_cs_bar     = (state != S_READ);
    adc_rd_bar     = (state != S_READ);
  end

  always_ff @(posedge clkin or negedge rst_bar) begin
    if (!rst_bar)                cnt <= '0;
    else if (state != nxt)       cnt <= '0;
    else if (state == S_START || state == S_WAIT || state == S_READ)
                                 cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clkin or negedge rst_bar) begin
    if (!rst_bar)               seen_rise <= 1'b0;
    else if (state != S_WAIT)   seen_rise <= 1'b0;
    else if (busy_p1)           seen_rise <= 1'b1;
  end

  always_ff @(posedge clkin or negedge rst_bar) begin
    if (!rst_bar)                           chan <= '0;
    else if (state == S_IDLE && tick)       chan <= '0;
    else if (state == S_NEXT && !last_ch)   chan <= chan + 1'b1;
  end

  // ---- capture / handshake stage
  always_ff @(posedge clkin or negedge rst_bar) begin
    if (!rst_bar) begin
      dout       <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
    end else if (last_rd) begin
      dout       <= adc_db;
      dout_ch    <= chan;
      dout_valid <= 1'b1;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

  always_ff @(posedge clkin or negedge rst_bar) begin
    if (!rst_bar) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (tick && state != S_IDLE) overrun <= 1'b1;
      if (to_hit)                  timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed bench for adc_capture_sequencer: a table of expected words across
// four frames on a default instance, plus overrun/reset sequences on a fast one.
module tb_adc_capture_sequencer;

  localparam int SDA = 1250;
  localparam int SDB = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- instance A: default parameters
  logic        rst_a = 1'b1, en_a = 1'b0, busy_a, rdy_a = 1'b0;
  logic [11:0] db_a, dout_a;
  logic        convst_a, cs_a, rd_a, vld_a, ovr_a, to_a;
  logic [2:0]  addr_a, dch_a;

  adc_capture_sequencer u_dut (
    .clkin(clk), .rst_bar(rst_a), .en(en_a), .adc_busy(busy_a), .adc_db(db_a),
    .adc_convst_bar(convst_a), .adc_cs_bar(cs_a), .adc_rd_bar(rd_a), .adc_addr(addr_a),
    .dout(dout_a), .dout_ch(dch_a), .dout_valid(vld_a), .dout_ready(rdy_a),
    .overrun(ovr_a), .timeout_err(to_a)
  );

  // ADC model: busy rises 2 cycles after convst falls, high 10 cycles; data 0x100+ch
  int         kill_ch = -1;
  int         bt_a = 0;
  logic       cvq_a = 1'b1;
  logic [2:0] ch_a = 3'd0;
  always @(posedge clk) begin
    cvq_a <= convst_a;
    if (cvq_a && !convst_a && (int'(addr_a) != kill_ch)) begin
      bt_a <= 12;
      ch_a <= addr_a;
    end else if (bt_a > 0) begin
      bt_a <= bt_a - 1;
    end
  end
  assign busy_a = (bt_a > 0) && (bt_a <= 10);
  assign db_a   = 12'h100 + {9'd0, ch_a};

  // ---------------- instance B: short frame period
  logic        rst_b = 1'b1, busy_b;
  logic        en_b = 1'b1, rdy_b = 1'b1;
  logic [11:0] db_b, dout_b;
  logic        convst_b, cs_b, rd_b, vld_b, ovr_b, to_b;
  logic [2:0]  addr_b, dch_b;

  adc_capture_sequencer #(.SAMPLE_DIV(SDB)) u_ovr (
    .clkin(clk), .rst_bar(rst_b), .en(en_b), .adc_busy(busy_b), .adc_db(db_b),
    .adc_convst_bar(convst_b), .adc_cs_bar(cs_b), .adc_rd_bar(rd_b), .adc_addr(addr_b),
    .dout(dout_b), .dout_ch(dch_b), .dout_valid(vld_b), .dout_ready(rdy_b),
    .overrun(ovr_b), .timeout_err(to_b)
  );

  int         bt_b = 0;
  logic       cvq_b = 1'b1;
  logic [2:0] ch_b = 3'd0;
  always @(posedge clk) begin
    cvq_b <= convst_b;
    if (cvq_b && !convst_b) begin
      bt_b <= 12;
      ch_b <= addr_b;
    end else if (bt_b > 0) begin
      bt_b <= bt_b - 1;
    end
  end
  assign busy_b = (bt_b > 0) && (bt_b <= 10);
  assign db_b   = 12'h100 + {9'd0, ch_b};

  // ---------------- monitors
  int         acc_a = 0, falls_a = 0, low_run = 0;
  logic       cvp_a = 1'b1;
  logic [2:0] addrp_a = 3'd0;
  always @(negedge clk) begin
    if (rst_a) begin
      if (vld_a && rdy_a) acc_a++;
      if (cvp_a && !convst_a) begin
        chk($sformatf("addr_at_convst[%0d]", falls_a), addr_a, falls_a % 8);
        chk($sformatf("addr_settled[%0d]", falls_a), addrp_a, falls_a % 8);
        falls_a++;
      end
      if (!convst_a) low_run++;
      else if (low_run != 0) begin
        chk("convst_low_width", low_run, 2);
        low_run = 0;
      end
      cvp_a   = convst_a;
      addrp_a = addr_a;
    end
  end

  int          b_cnt = 0;
  logic [11:0] b_d  [16];
  logic [2:0]  b_ch [16];
  always @(negedge clk) begin
    if (rst_b && vld_b) begin
      if (b_cnt < 16) begin
        b_d[b_cnt]  = dout_b;
        b_ch[b_cnt] = dch_b;
      end
      b_cnt++;
    end
  end

  // ---------------- vector table
  typedef struct {
    int         hold;     // cycles dout_ready stays low once valid is seen
    int         kill;     // channel whose busy never rises (-1: none)
    bit         drop_en;  // drop en while this word is pending
    logic [11:0] exp_d;
    logic [2:0]  exp_ch;
    bit          exp_to;
  } vec_t;

  function automatic vec_t mk(int hold, int kill, bit drop, logic [11:0] d,
                              logic [2:0] ch, bit to);
    vec_t v;
    v.hold = hold; v.kill = kill; v.drop_en = drop;
    v.exp_d = d; v.exp_ch = ch; v.exp_to = to;
    return v;
  endfunction

  vec_t vec [31];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int w, k;
    // frame 1: plain capture
    vec[0]  = mk(0, -1, 0, 12'h100, 3'd0, 0); vec[1]  = mk(0, -1, 0, 12'h101, 3'd1, 0);
    vec[2]  = mk(0, -1, 0, 12'h102, 3'd2, 0); vec[3]  = mk(0, -1, 0, 12'h103, 3'd3, 0);
    vec[4]  = mk(0, -1, 0, 12'h104, 3'd4, 0); vec[5]  = mk(0, -1, 0, 12'h105, 3'd5, 0);
    vec[6]  = mk(0, -1, 0, 12'h106, 3'd6, 0); vec[7]  = mk(0, -1, 0, 12'h107, 3'd7, 0);
    // frame 2: backpressure on ch3
    vec[8]  = mk(0, -1, 0, 12'h100, 3'd0, 0); vec[9]  = mk(0, -1, 0, 12'h101, 3'd1, 0);
    vec[10] = mk(0, -1, 0, 12'h102, 3'd2, 0); vec[11] = mk(20, -1, 0, 12'h103, 3'd3, 0);
    vec[12] = mk(0, -1, 0, 12'h104, 3'd4, 0); vec[13] = mk(0, -1, 0, 12'h105, 3'd5, 0);
    vec[14] = mk(0, -1, 0, 12'h106, 3'd6, 0); vec[15] = mk(0, -1, 0, 12'h107, 3'd7, 0);
    // frame 3: ch5 never busy -> skipped, timeout flagged
    vec[16] = mk(0, 5, 0, 12'h100, 3'd0, 0);  vec[17] = mk(0, 5, 0, 12'h101, 3'd1, 0);
    vec[18] = mk(0, 5, 0, 12'h102, 3'd2, 0);  vec[19] = mk(0, 5, 0, 12'h103, 3'd3, 0);
    vec[20] = mk(0, 5, 0, 12'h104, 3'd4, 0);  vec[21] = mk(0, 5, 0, 12'h106, 3'd6, 1);
    vec[22] = mk(0, 5, 0, 12'h107, 3'd7, 1);
    // frame 4: en dropped during ch2
    vec[23] = mk(0, -1, 0, 12'h100, 3'd0, 1); vec[24] = mk(0, -1, 0, 12'h101, 3'd1, 1);
    vec[25] = mk(0, -1, 1, 12'h102, 3'd2, 1); vec[26] = mk(0, -1, 0, 12'h103, 3'd3, 1);
    vec[27] = mk(0, -1, 0, 12'h104, 3'd4, 1); vec[28] = mk(0, -1, 0, 12'h105, 3'd5, 1);
    vec[29] = mk(0, -1, 0, 12'h106, 3'd6, 1); vec[30] = mk(0, -1, 0, 12'h107, 3'd7, 1);

    // reset values
    #2;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #2;
    chk("rst_convst", convst_a, 1); chk("rst_cs", cs_a, 1); chk("rst_rd", rd_a, 1);
    chk("rst_addr", addr_a, 0);     chk("rst_dout", dout_a, 0); chk("rst_dout_ch", dch_a, 0);
    chk("rst_valid", vld_a, 0);     chk("rst_overrun", ovr_a, 0); chk("rst_timeout", to_a, 0);
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    en_a  = 1'b1;

    for (int i = 0; i < 31; i++) begin
      kill_ch = vec[i].kill;
      w = 0;
      while (!vld_a && w < 4000) begin
        @(negedge clk);
        w++;
      end
      if (!vld_a) begin
        chk($sformatf("wait_valid[%0d]", i), vld_a, 1);
        break;
      end
      if (vec[i].drop_en) en_a = 1'b0;
      for (int h = 0; h < vec[i].hold; h++) begin
        chk($sformatf("hold_valid[%0d]", h), vld_a, 1);
        chk($sformatf("hold_dout[%0d]", h), dout_a, vec[i].exp_d);
        chk($sformatf("hold_ch[%0d]", h), dch_a, vec[i].exp_ch);
        @(negedge clk);
      end
      chk($sformatf("dout[%0d]", i), dout_a, vec[i].exp_d);
      chk($sformatf("dout_ch[%0d]", i), dch_a, vec[i].exp_ch);
      chk($sformatf("timeout_err[%0d]", i), to_a, vec[i].exp_to);
      chk($sformatf("overrun[%0d]", i), ovr_a, 0);
      rdy_a = 1'b1;
      @(negedge clk);
      chk($sformatf("valid_after_accept[%0d]", i), vld_a, 0);
      rdy_a = 1'b0;
    end
    chk("accept_count", acc_a, 31);

    // en low: no further frames, divider parked at 0
    repeat (3000) @(negedge clk);
    chk("convst_falls_total", falls_a, 32);
    en_a = 1'b1;
    k = 0;
    while (convst_a && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("restart_latency", k, SDA + 1);
    en_a = 1'b0;

    // instance B: frame longer than the tick period
    @(negedge clk);
    rst_b = 1'b1;
    w = 0;
    while (b_cnt < 8 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("b_frame_words", b_cnt >= 8, 1);
    chk("b_overrun", ovr_b, 1);
    k = 0;
    while (convst_b && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("b_next_frame_on_tick", (k >= 2) && (k <= SDB + 4), 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b_dout[%0d]", i), b_d[i], vec[i].exp_d);
      chk($sformatf("b_dout_ch[%0d]", i), b_ch[i], vec[i].exp_ch);
    end

    // reset asserted while the read strobe is low
    w = 0;
    while (rd_b && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("b_reach_read", rd_b, 0);
    #1 rst_b = 1'b0;
    #1;
    chk("mid_rst_convst", convst_b, 1); chk("mid_rst_cs", cs_b, 1); chk("mid_rst_rd", rd_b, 1);
    chk("mid_rst_addr", addr_b, 0);     chk("mid_rst_dout", dout_b, 0);
    chk("mid_rst_dout_ch", dch_b, 0);   chk("mid_rst_valid", vld_b, 0);
    chk("mid_rst_overrun", ovr_b, 0);   chk("mid_rst_timeout", to_b, 0);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    k = 0;
    while (convst_b && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("b_first_frame_after_reset", k, SDB + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_capture_sequencer.md
# adc_capture_sequencer

Upstream stage of the CPLD parallel-to-SPI serializer in the beamforming front end. Sequences the multi-channel parallel ADC: paces frames from a sample-rate divider, steps the channel mux, pulses conversion start, waits on BUSY and strobes the read. Latches each 12-bit word and hands it to the serializer over a valid/ready handshake. Flags frame overruns and ADC timeouts to the DSP.

## Interface
- NCH, 8: channels per frame (2..16)
- DW, 12: ADC data width
- SAMPLE_DIV, 1250: clkin cycles per frame tick (≥ 2)
- CONV_LOW, 2: adc_convst_bar low width, cycles (≥ 1)
- RD_CYCLES, 3: adc_rd_bar low width, cycles (≥ 1)
- BUSY_TIMEOUT, 64: max cycles in WAIT_BUSY
- clkin  in  1  system clock; all logic on rising edge
- rst_bar  in  1  reset, asynchronous, active-low
- en  in  1  enable; frames start only while high
- adc_busy  in  1  ADC BUSY, high during conversion; synchronised internally with a 2-flop synchroniser
- adc_db  in  DW  ADC parallel data bus
- adc_convst_bar  out  1  conversion start, active-low
- adc_cs_bar  out  1  ADC chip select, active-low during READ
- adc_rd_bar  out  1  ADC read strobe, active-low
- adc_addr  out  clog2(NCH)  mux channel select
- dout  out  DW  captured sample
- dout_ch  out  clog2(NCH)  channel of dout
- dout_valid  out  1  dout/dout_ch valid
- dout_ready  in  1  serializer accepts the word this cycle
- overrun  out  1  sticky: tick arrived while frame busy
- timeout_err  out  1  sticky: BUSY_TIMEOUT expired

## Operation
- Reset values: adc_convst_bar=1, adc_cs_bar=1, adc_rd_bar=1, adc_addr=0, dout=0, dout_ch=0, dout_valid=0, overrun=0, timeout_err=0; FSM=IDLE, divider=0, channel=0.
- Divider: counts 0..SAMPLE_DIV-1 while en=1, tick on terminal count; held at 0 while en=0.
- IDLE: on tick → START, channel=0, adc_addr=0.
- START: adc_convst_bar=0 for CONV_LOW cycles → WAIT_BUSY.
- WAIT_BUSY: wait for synchronised busy rising, then falling. Falling → READ. Counter reaching BUSY_TIMEOUT → set timeout_err, skip channel (NEXT), no word emitted.
- READ: adc_cs_bar=0, adc_rd_bar=0 for RD_CYCLES; latch adc_db into dout, channel into dout_ch on last low cycle; then strobes high, dout_valid=1 → HOLD.
- HOLD: dout_valid held, dout/dout_ch stable until dout_valid & dout_ready; then dout_valid=0 → NEXT.
- NEXT: channel==NCH-1 → IDLE; else channel+1, adc_addr updated, → START.
- Channel counter wraps to 0 only at frame start; never exceeds NCH-1.
- Tick while FSM≠IDLE: overrun=1, tick dropped; current frame continues.
- en falling mid-frame: current frame completes; no new frame starts.
- overrun/timeout_err cleared only by reset.

## Timing
- adc_addr changes ≥ 1 cycle before adc_convst_bar falls (settling).
- START→WAIT_BUSY: exactly CONV_LOW cycles of convst low.
- Busy seen 2 cycles after pin change (synchroniser).
- READ latch to dout_valid=1: 1 cycle.
- dout_ready ignored when dout_valid=0; accept on the same cycle valid & ready both high.
- Per channel, ready tied high, adc_busy pulse B cycles: CONV_LOW + B + 4 + RD_CYCLES + 2 cycles (±1 on edge alignment).
- Frame must finish within SAMPLE_DIV cycles, else overrun.

## Test plan
- Reset mid-READ (adc_rd_bar low): all outputs go to reset values immediately; after release, first frame starts on the tick SAMPLE_DIV cycles later.
- NCH=8, dout_ready=1, ADC model returns 0x100+ch, busy 10 cycles: 8 words 0x100..0x107 with dout_ch 0..7 in order; adc_addr stays 0..7; then IDLE.
- dout_ready held low 20 cycles on ch 3: dout_valid, dout=0x103 and dout_ch=3 are stable for all 20 cycles; exactly one accept; no channel skipped.
- Busy never asserted on ch 5: timeout_err=1 after BUSY_TIMEOUT cycles; ch 5 emits no word; ch 6..7 are delivered.
- SAMPLE_DIV=20 with a frame longer than 20 cycles: overrun=1; the current frame completes intact; the next frame starts on the following tick.
- en dropped during ch 2: ch 2..7 complete; no further convst pulses; divider held at 0.
